fifo_tlp: RTL and testbench

Synchronous FIFO buffer for the transaction layer, instantiated once per virtual channel on both sides of the arbiter. The upstream (input) instances supply `empty` to the arbiter and accept its `pop`; the downstream (output) instances accept its `push` and return `almost_full` as back-pressure. It provides configurable almost-full and almost-empty thresholds, registered read data, and a sticky overflow/underflow error flag.

---
 rtl/tlp_pkg.sv | 16 +
 rtl/fifo_mem.sv | 21 ++
 rtl/fifo_tlp.sv | 87 ++++++++
 tb/tb_fifo_tlp.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared transaction-layer constants and types for the VC FIFOs, the arbiter and the benches.
package tlp_pkg;

  localparam int unsigned DATA_WIDTH = 6;
  localparam int unsigned ADDR_WIDTH = 3;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  localparam cnt_t THR_ALTO_RST = CNT_WIDTH'(DEPTH - 1);
  localparam cnt_t THR_BAJO_RST = CNT_WIDTH'(1);

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem
  import tlp_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ptr_t  waddr,
  input  word_t wdata,
  input  ptr_t  raddr,
  output word_t rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_tlp.sv
// Per-virtual-channel TLP FIFO: pointers, occupancy, threshold flags, registered read port
// and a sticky overflow/underflow error.
module fifo_tlp
  import tlp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CNT_WIDTH-1:0] umbral_alto,
  input  logic [CNT_WIDTH-1:0] umbral_bajo,
  input  logic                 push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                 pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  cnt_t  count;
  cnt_t  thr_alto;
  cnt_t  thr_bajo;
  word_t rd_word;
  logic  push_ok;
  logic  pop_ok;
  logic  err_evt;

  // A push into a full FIFO is still legal when a pop frees the slot in the same cycle.
  always_comb begin
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
    err_evt = (push && full && !pop) || (pop && empty);
  end

  fifo_mem u_mem (
    .clk   (clk),
    .we    (push_ok && !reset),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
      thr_alto  <= THR_ALTO_RST;
      thr_bajo  <= THR_BAJO_RST;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= rd_word;
      end
      valid_out <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      if (err_evt) error <= 1'b1;
      if (init) begin
        thr_alto <= umbral_alto;
        thr_bajo <= umbral_bajo;
      end
    end
  end

  // Moore flags: decoded only from registered occupancy and thresholds.
  always_comb begin
    empty        = (count == '0);
    full         = (count == CNT_WIDTH'(DEPTH));
    almost_full  = (count >= thr_alto);
    almost_empty = (count <= thr_bajo);
  end

endmodule

// File: tb/tb_fifo_tlp.sv
// Scoreboard bench for fifo_tlp: directed test-plan sequences followed by random traffic,
// checked against a queue-based reference model.
module tb_fifo_tlp;
  import tlp_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset, init, push, pop;
  logic [CNT_WIDTH-1:0]  umbral_alto, umbral_bajo;
  logic [DATA_WIDTH-1:0] data_in, data_out;
  logic                  valid_out, empty, full, almost_full, almost_empty, error;

  fifo_tlp dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_WIDTH-1:0] model_q [$];
  logic [DATA_WIDTH-1:0] exp_q   [$];
  int thr_a = int'(DEPTH) - 1;
  int thr_b = 1;
  bit m_err = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference model across the edge, then check the flags.
  task automatic step(input bit rst, input bit ps, input bit pp, input logic [DATA_WIDTH-1:0] d,
                      input bit in_i = 1'b0, input int a = 0, input int b = 0);
    int  s;
    bit  push_acc, pop_acc;
    reset = rst; push = ps; pop = pp; data_in = d; init = in_i;
    umbral_alto = CNT_WIDTH'(a); umbral_bajo = CNT_WIDTH'(b);
    @(posedge clk);
    s = model_q.size();
    if (rst) begin
      model_q.delete();
      thr_a = int'(DEPTH) - 1; thr_b = 1; m_err = 1'b0; m_valid = 1'b0;
    end else begin
      pop_acc  = pp && (s > 0);
      push_acc = ps && ((s < int'(DEPTH)) || pp);
      if ((ps && !pp && s == int'(DEPTH)) || (pp && s == 0)) m_err = 1'b1;
      m_valid = pop_acc;
      if (pop_acc) exp_q.push_back(model_q.pop_front());
      if (push_acc) model_q.push_back(d);
      if (in_i) begin thr_a = a; thr_b = b; end
    end
    #1;
    s = model_q.size();
    check("empty",        32'(empty),        32'(s == 0));
    check("full",         32'(full),         32'(s == int'(DEPTH)));
    check("almost_full",  32'(almost_full),  32'(s >= thr_a));
    check("almost_empty", 32'(almost_empty), 32'(s <= thr_b));
    check("error",        32'(error),        32'(m_err));
    check("valid_out",    32'(valid_out),    32'(m_valid));
  endtask

  // Monitor: every presented word must be the oldest outstanding expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL data_out: unexpected word %0h with nothing expected at %0t", data_out, $time);
        end else begin
          logic [DATA_WIDTH-1:0] w;
          w = exp_q.pop_front();
          if (data_out !== w) begin
            n_bad++;
            $display("FAIL data_out: got %0h expected %0h at %0t", data_out, w, $time);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_alto = '0; umbral_bajo = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("data_out_rst", 32'(data_out), 32'h0);

    // Fill 0x01..0x08, then overflow attempt, then drain in order
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, DATA_WIDTH'(i));
    step(1'b0, 1'b1, 1'b0, 6'h3F);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Push+pop on empty: push wins, pop flagged
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 6'h15);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Full with concurrent push+pop: pointers wrap, no error
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DATA_WIDTH'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 6'h2A);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, '0);

    // New thresholds 4/2, then fill
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 4, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, DATA_WIDTH'($urandom));

    // Reset mid-burst at count 5, then underflow
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DATA_WIDTH'($urandom));
    step(1'b1, 1'b1, 1'b1, 6'h11, 1'b1, 2, 6);
    check("data_out_rst2", 32'(data_out), 32'h0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Random traffic with occasional reprogramming and reset
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           DATA_WIDTH'($urandom), (r >= 2 && r < 7),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
